ctrl_sequencer: RTL

//  Parametrised CPU control unit for the Harvard no-pipeline core: owns the instruction-cycle FSM
//  (IDLE/FETCH/EXEC1/EXEC2/HALT/FAULT), decodes the opcode and drives all datapath strobes.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/ctrl_decode.sv | 39 +++
 rtl/ctrl_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the Harvard no-pipeline control unit: FSM state encoding,
// opcode constants (also used by the assembler and bench) and decoded opcode classes.
package ctrl_pkg;

    localparam logic [3:0] OP_STA = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b0001;
    localparam logic [3:0] OP_JEQ = 4'b0010;  // 001x: low bit is don't-care
    localparam logic [3:0] OP_STP = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_JMS = 4'b0110;
    localparam logic [3:0] OP_BBL = 4'b0111;
    localparam logic [3:0] OP_LDR = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_FETCH = 6'b000010,
        ST_EXEC1 = 6'b000100,
        ST_EXEC2 = 6'b001000,
        ST_HALT  = 6'b010000,
        ST_FAULT = 6'b100000
    } state_t;

    typedef enum logic [9:0] {
        CL_NOP = 10'b00_0000_0001,
        CL_STA = 10'b00_0000_0010,
        CL_JMP = 10'b00_0000_0100,
        CL_JEQ = 10'b00_0000_1000,
        CL_STP = 10'b00_0001_0000,
        CL_LDA = 10'b00_0010_0000,
        CL_JMS = 10'b00_0100_0000,
        CL_BBL = 10'b00_1000_0000,
        CL_LDR = 10'b01_0000_0000,
        CL_HLT = 10'b10_0000_0000
    } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps the IR opcode to a one-hot instruction class.
// Any set bit above inst[3:0] demotes the instruction to NOP.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] inst,
    output op_class_t        op_class
);

    logic upper_zero;

    // NOTE: every variable written in a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 4; i < OPC_W; i++) begin
            if (inst[i]) upper_zero = 1'b0;
        end

        op_class = CL_NOP;
        if (upper_zero) begin
            case (inst[3:0])
                OP_STA:           op_class = CL_STA;
                OP_JMP:           op_class = CL_JMP;
                OP_JEQ, 4'b0011:  op_class = CL_JEQ;
                OP_STP:           op_class = CL_STP;
                OP_LDA:           op_class = CL_LDA;
                OP_JMS:           op_class = CL_JMS;
                OP_BBL:           op_class = CL_BBL;
                OP_LDR:           op_class = CL_LDR;
                OP_HLT:           op_class = CL_HLT;
                default:          op_class = CL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction-cycle FSM and return-stack depth tracker for the Harvard no-pipeline core.
// Strobes are decoded combinationally from state, opcode class, eq, mem_ready and sp.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPC_W       = 4,
    parameter int STACK_DEPTH = 8,
    parameter int SP_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [OPC_W-1:0] inst,
    input  logic             eq,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             jump_mux,
    output logic             stack_mux,
    output logic             push,
    output logic             pop,
    output logic             WrEn,
    output logic             acc_load,
    output logic             e,
    output logic             halted,
    output logic             fault,
    output logic [SP_W-1:0]  sp
);

    localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(STACK_DEPTH);

    state_t    state;
    op_class_t op_class;
    logic      stack_full;
    logic      stack_empty;

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .inst     (inst),
        .op_class (op_class)
    );

    assign stack_full  = (sp >= DEPTH_SP);
    assign stack_empty = (sp == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sp    <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (run) state <= ST_FETCH;
                ST_FETCH: if (mem_ready) state <= ST_EXEC1;
                ST_EXEC1: begin
                    case (op_class)
                        CL_JMP, CL_STP: state <= ST_FETCH;
                        CL_JEQ:         state <= eq ? ST_EXEC2 : ST_FETCH;
                        CL_JMS: begin
                            if (stack_full) begin
                                state <= ST_FAULT;
                            end else begin
                                sp    <= sp + 1'b1;
                                state <= ST_FETCH;
                            end
                        end
                        CL_BBL: begin
                            if (stack_empty) begin
                                state <= ST_FAULT;
                            end else begin
                                sp    <= sp - 1'b1;
                                state <= ST_FETCH;
                            end
                        end
                        CL_STA:  if (mem_ready) state <= ST_EXEC2;
                        CL_HLT:  state <= ST_HALT;
                        default: state <= ST_EXEC2;  // LDA, LDR, NOP
                    endcase
                end
                ST_EXEC2: state <= run ? ST_FETCH : ST_IDLE;
                ST_HALT, ST_FAULT: begin
                    if (clr) begin
                        state <= ST_IDLE;
                        sp    <= '0;
                    end
                end
                default: state <= ST_IDLE;  // recover from an illegal one-hot code
            endcase
        end
    end

    always_comb begin
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        jump_mux  = 1'b0;
        stack_mux = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        WrEn      = 1'b0;
        acc_load  = 1'b0;
        e         = 1'b0;
        halted    = (state == ST_HALT);
        fault     = (state == ST_FAULT);

        case (state)
            ST_FETCH: begin
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            ST_EXEC1: begin
                case (op_class)
                    CL_JMP, CL_STP: begin
                        pc_load  = 1'b1;
                        jump_mux = 1'b1;
                    end
                    CL_JEQ: begin
                        pc_load  = ~eq;
                        jump_mux = ~eq;
                    end
                    CL_JMS: begin
                        push     = ~stack_full;
                        pc_load  = ~stack_full;
                        jump_mux = ~stack_full;
                    end
                    CL_BBL: begin
                        pop       = ~stack_empty;
                        pc_load   = ~stack_empty;
                        jump_mux  = ~stack_empty;
                        stack_mux = ~stack_empty;
                    end
                    CL_STA:         WrEn = 1'b1;
                    CL_LDA, CL_LDR: e    = 1'b1;
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                pc_inc = 1'b1;
                if (op_class == CL_LDA || op_class == CL_LDR) begin
                    acc_load = 1'b1;
                    e        = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
